// File: rtl/lift_pkg.sv
// Shared types and limits for the lifting-pass sequencer.
// Holds the FSM state set, the address width and the legal row-length range.
package lift_pkg;

  localparam int ADDR_W = 7;

  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t MIN_LEN = 7'd4;
  localparam addr_t MAX_LEN = 7'd126;

  typedef enum logic [2:0] {
    IDLE,
    RD1,
    WR1,
    RD2,
    WR2,
    DONE
  } state_e;

  // A row is legal when it is even and within the supported range.
  function automatic logic len_ok(input addr_t n);
    return (n[0] == 1'b0) && (n >= MIN_LEN) && (n <= MAX_LEN);
  endfunction

  // First sample index of a pass: 1 for the odd pass, 0 for the even pass.
  function automatic addr_t first_idx(input logic odd);
    return {{(ADDR_W-1){1'b0}}, odd};
  endfunction

endpackage

// File: rtl/lift_seq_if.sv
// Control/address bundle between the row sequencer and its requester/datapath.
// master drives requests and hold; slave (the sequencer) drives addresses and status.
interface lift_seq_if;
  import lift_pkg::*;

  logic  start;
  logic  fwd_inv_in;
  addr_t row_len;
  logic  hold;

  addr_t pix_addr_l;
  addr_t pix_addr_sam;
  addr_t pix_addr_r;
  logic  pix_we;
  logic  pix_even_odd;
  logic  pix_fwd_inv;
  logic  busy;
  logic  done;
  logic  err;

  modport master (
    output start, fwd_inv_in, row_len, hold,
    input  pix_addr_l, pix_addr_sam, pix_addr_r, pix_we,
    input  pix_even_odd, pix_fwd_inv, busy, done, err
  );

  modport slave (
    input  start, fwd_inv_in, row_len, hold,
    output pix_addr_l, pix_addr_sam, pix_addr_r, pix_we,
    output pix_even_odd, pix_fwd_inv, busy, done, err
  );

endinterface

// File: rtl/lift_addr_gen.sv
// Neighbour address generator with symmetric extension at both row edges.
// Sample 0 mirrors its left neighbour to 1; sample N-1 mirrors its right to N-2.
module lift_addr_gen
  import lift_pkg::*;
(
  input  addr_t i_i,
  input  addr_t i_n,
  output addr_t o_l,
  output addr_t o_sam,
  output addr_t o_r
);

  assign o_sam = i_i;
  assign o_l   = (i_i == '0) ? 7'd1 : (i_i - 7'd1);
  assign o_r   = (i_i == (i_n - 7'd1)) ? (i_n - 7'd2) : (i_i + 7'd1);

endmodule

// File: rtl/lift_seq.sv
// Row sequencer for a two-pass lifting transform: walks one parity pass then the
// other, two cycles per sample (read, then write-back), with a consumer stall.
module lift_seq
  import lift_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  lift_seq_if.slave  bus
);

  state_e r_state, w_state_nxt;
  addr_t  r_idx,   w_idx_nxt;
  addr_t  r_len,   w_len_nxt;
  logic   r_fwd_inv, w_fwd_inv_nxt;
  logic   r_odd,   w_odd_nxt;
  logic   r_err,   w_err_nxt;

  logic   w_active;
  logic   w_wr;
  logic   w_last;
  addr_t  w_l, w_sam, w_r;

  // Last sample of a pass is N-2 for the even pass and N-1 for the odd pass.
  assign w_last = (r_idx == (r_len - 7'd2 + first_idx(r_odd)));

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_len_nxt     = r_len;
    w_fwd_inv_nxt = r_fwd_inv;
    w_odd_nxt     = r_odd;
    w_err_nxt     = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.start) begin
          if (len_ok(bus.row_len)) begin
            w_len_nxt     = bus.row_len;
            w_fwd_inv_nxt = bus.fwd_inv_in;
            w_odd_nxt     = bus.fwd_inv_in;
            w_idx_nxt     = first_idx(bus.fwd_inv_in);
            w_state_nxt   = RD1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      RD1: if (!bus.hold) w_state_nxt = WR1;
      WR1: begin
        if (!bus.hold) begin
          if (w_last) begin
            w_odd_nxt   = ~r_odd;
            w_idx_nxt   = first_idx(~r_odd);
            w_state_nxt = RD2;
          end else begin
            w_idx_nxt   = r_idx + 7'd2;
            w_state_nxt = RD1;
          end
        end
      end
      RD2: if (!bus.hold) w_state_nxt = WR2;
      WR2: begin
        if (!bus.hold) begin
          if (w_last) begin
            w_state_nxt = DONE;
          end else begin
            w_idx_nxt   = r_idx + 7'd2;
            w_state_nxt = RD2;
          end
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_len     <= '0;
      r_fwd_inv <= 1'b0;
      r_odd     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_len     <= w_len_nxt;
      r_fwd_inv <= w_fwd_inv_nxt;
      r_odd     <= w_odd_nxt;
      r_err     <= w_err_nxt;
    end
  end

  lift_addr_gen u_addr_gen (
    .i_i   (r_idx),
    .i_n   (r_len),
    .o_l   (w_l),
    .o_sam (w_sam),
    .o_r   (w_r)
  );

  assign w_active = (r_state == RD1) || (r_state == WR1) ||
                    (r_state == RD2) || (r_state == WR2);
  assign w_wr     = (r_state == WR1) || (r_state == WR2);

  // Addresses read as zero outside a row so idle/reset outputs are quiet.
  assign bus.pix_addr_l   = w_active ? w_l   : '0;
  assign bus.pix_addr_sam = w_active ? w_sam : '0;
  assign bus.pix_addr_r   = w_active ? w_r   : '0;
  assign bus.pix_we       = w_wr && !bus.hold;
  assign bus.pix_even_odd = w_active && r_odd;
  assign bus.pix_fwd_inv  = r_fwd_inv;
  assign bus.busy         = w_active;
  assign bus.done         = (r_state == DONE);
  assign bus.err          = r_err;

endmodule
